// File: rtl/mem_bus_ctrl_if.sv
// Request/memory/I/O signal bundle between the load/store datapath and mem_bus_ctrl.
// slave = the controller, master = the requester/memory/port side.
interface mem_bus_ctrl_if;
  logic        iReq;
  logic        iWE;
  logic [31:0] iAddr;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oAck;
  logic        oFault;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [31:0] iMemData;
  logic [31:0] oOutPort;
  logic [31:0] iInPort;

  modport slave (
    input  iReq, iWE, iAddr, iData, iMemData, iInPort,
    output oData, oAck, oFault, oMemRead, oMemWrite, oMemAddr, oMemData, oOutPort
  );

  modport master (
    output iReq, iWE, iAddr, iData, iMemData, iInPort,
    input  oData, oAck, oFault, oMemRead, oMemWrite, oMemAddr, oMemData, oOutPort
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding word access controller: decodes to memory, I/O ports or fault,
// sequences the synchronous memory read plus optional wait states, acks for one cycle.
//
// state   | meaning
// IDLE    | waiting for iReq; request latched and decoded here
// MEM_WR  | one cycle memory write strobe
// MEM_RD  | address presented to memory, read strobe high
// RD_WAIT | read strobe held while wait counter runs down, data captured at zero
// ACK     | one-cycle completion pulse, iReq ignored
module mem_bus_ctrl #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00,
  parameter int          WAIT_STATES = 0
) (
  input logic           iClk,
  input logic           nRst,
  mem_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MEM_WR, MEM_RD, RD_WAIT, ACK} state_t;

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] outport_q, outport_d;
  logic        fault_q, fault_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        io_hit;
  logic [7:0]  io_off;

  // I/O window is assumed 256-byte aligned
  assign io_hit = (bus.iAddr[31:8] == IO_BASE[31:8]);
  assign io_off = bus.iAddr[7:0];

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      outport_q <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      outport_q <= outport_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    outport_d = outport_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.iReq) begin
          addr_d  = bus.iAddr;
          wdata_d = bus.iData;
          fault_d = 1'b0;
          if (bus.iAddr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ACK;
          end else if (io_hit) begin
            state_d = ACK;
            if (io_off == 8'h00) begin
              if (bus.iWE) outport_d = bus.iData;
              else         data_d    = outport_q;
            end else if (io_off == 8'h04) begin
              if (!bus.iWE) data_d = bus.iInPort;
            end else begin
              fault_d = 1'b1;
            end
          end else if (bus.iAddr[31:2] >= MEM_LIMIT) begin
            fault_d = 1'b1;
            state_d = ACK;
          end else begin
            state_d = bus.iWE ? MEM_WR : MEM_RD;
          end
        end
      end
      MEM_WR:  state_d = ACK;
      MEM_RD: begin
        cnt_d   = WAIT_LOAD;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = bus.iMemData;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.oAck      = (state_q == ACK);
  assign bus.oMemWrite = (state_q == MEM_WR);
  assign bus.oMemRead  = (state_q == MEM_RD) || (state_q == RD_WAIT);
  assign bus.oMemAddr  = addr_q;
  assign bus.oMemData  = wdata_q;
  assign bus.oData     = data_q;
  assign bus.oFault    = fault_q;
  assign bus.oOutPort  = outport_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with no wait states, one with three,
// each backed by a synchronous-read memory model.
module tb_mem_bus_ctrl;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;

  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] inport = '0;
  logic        sel = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_bus_ctrl_if bus0 ();
  mem_bus_ctrl_if bus1 ();

  mem_bus_ctrl #(.MEM_WORDS(1024), .IO_BASE(IO_BASE), .WAIT_STATES(0)) dut0 (
    .iClk(iClk), .nRst(nRst), .bus(bus0.slave)
  );
  mem_bus_ctrl #(.MEM_WORDS(1024), .IO_BASE(IO_BASE), .WAIT_STATES(3)) dut1 (
    .iClk(iClk), .nRst(nRst), .bus(bus1.slave)
  );

  assign bus0.iReq    = req & ~sel;
  assign bus1.iReq    = req & sel;
  assign bus0.iWE     = we;
  assign bus1.iWE     = we;
  assign bus0.iAddr   = addr;
  assign bus1.iAddr   = addr;
  assign bus0.iData   = wdata;
  assign bus1.iData   = wdata;
  assign bus0.iInPort = inport;
  assign bus1.iInPort = inport;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] rd0, rd1;

  always @(posedge iClk) begin
    if (bus0.oMemWrite) mem0[bus0.oMemAddr[11:2]] <= bus0.oMemData;
    rd0 <= mem0[bus0.oMemAddr[11:2]];
    if (bus1.oMemWrite) mem1[bus1.oMemAddr[11:2]] <= bus1.oMemData;
    rd1 <= mem1[bus1.oMemAddr[11:2]];
  end
  assign bus0.iMemData = rd0;
  assign bus1.iMemData = rd1;

  wire        o_ack   = sel ? bus1.oAck      : bus0.oAck;
  wire        o_fault = sel ? bus1.oFault    : bus0.oFault;
  wire [31:0] o_data  = sel ? bus1.oData     : bus0.oData;
  wire        o_rd    = sel ? bus1.oMemRead  : bus0.oMemRead;
  wire        o_wr    = sel ? bus1.oMemWrite : bus0.oMemWrite;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request; returns cycles from accept edge to ack cycle (-1 on timeout),
  // strobe cycle counts up to the ack, and data/fault seen during the ack cycle.
  task automatic do_xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] rdata, output logic flt);
    lat = -1; nrd = 0; nwr = 0; rdata = 'x; flt = 1'bx;
    @(negedge iClk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge iClk);
    #1;
    req = 1'b0; addr = 32'h5555_5554; wdata = 32'h0BAD_0BAD;
    for (int c = 1; c <= 40; c++) begin
      @(negedge iClk);
      if (o_rd) nrd++;
      if (o_wr) nwr++;
      if (o_ack) begin
        lat = c; rdata = o_data; flt = o_fault;
        break;
      end
    end
  endtask

  int lat, nrd, nwr;
  logic [31:0] rdata;
  logic flt;
  int acks, first_ack, last_ack, rd_cyc;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem1[0]    = 32'h1234_5678;
    mem0[8]    = 32'h0BAD_C0DE;
    mem0[1023] = 32'hCAFE_F00D;

    #3;
    chk("rst_ack",     {31'b0, bus0.oAck},      32'h0);
    chk("rst_fault",   {31'b0, bus0.oFault},    32'h0);
    chk("rst_data",    bus0.oData,              32'h0);
    chk("rst_outport", bus0.oOutPort,           32'h0);
    chk("rst_memaddr", bus0.oMemAddr,           32'h0);
    chk("rst_strobes", {30'b0, bus0.oMemRead, bus0.oMemWrite}, 32'h0);

    @(negedge iClk);
    nRst = 1'b1;

    do_xact(1'b1, 32'h10, 32'hDEAD_BEEF, lat, nrd, nwr, rdata, flt);
    chk("wr_lat",   lat, 2);
    chk("wr_nwr",   nwr, 1);
    chk("wr_nrd",   nrd, 0);
    chk("wr_fault", {31'b0, flt}, 32'h0);
    chk("wr_mem",   mem0[4], 32'hDEAD_BEEF);

    do_xact(1'b0, 32'h10, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("rd_lat",   lat, 3);
    chk("rd_data",  rdata, 32'hDEAD_BEEF);
    chk("rd_fault", {31'b0, flt}, 32'h0);
    chk("rd_nrd",   nrd, 2);

    do_xact(1'b0, 32'hFFC, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("rd_top_lat",  lat, 3);
    chk("rd_top_data", rdata, 32'hCAFE_F00D);

    sel = 1'b1;
    do_xact(1'b0, 32'h0, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("ws3_lat",  lat, 6);
    chk("ws3_nrd",  nrd, 5);
    chk("ws3_data", rdata, 32'h1234_5678);
    sel = 1'b0;

    do_xact(1'b1, IO_BASE, 32'hA5, lat, nrd, nwr, rdata, flt);
    chk("io_wr_lat",     lat, 1);
    chk("io_wr_strobe",  nrd + nwr, 0);
    chk("io_wr_outport", bus0.oOutPort, 32'hA5);
    chk("io_wr_fault",   {31'b0, flt}, 32'h0);

    inport = 32'h77;
    do_xact(1'b0, IO_BASE + 32'h4, 32'h0, lat, nrd, nwr, rdata, flt);
    inport = 32'h99;
    chk("io_in_lat",  lat, 1);
    chk("io_in_data", rdata, 32'h77);

    do_xact(1'b0, IO_BASE, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("io_out_data", rdata, 32'hA5);

    do_xact(1'b0, 32'h2, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("mis_fault",  {31'b0, flt}, 32'h1);
    chk("mis_lat",    lat, 1);
    chk("mis_strobe", nrd + nwr, 0);
    chk("mis_data",   rdata, 32'hA5);

    do_xact(1'b0, 32'h1000, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("oor_fault",  {31'b0, flt}, 32'h1);
    chk("oor_lat",    lat, 1);
    chk("oor_strobe", nrd + nwr, 0);
    chk("oor_data",   rdata, 32'hA5);

    do_xact(1'b1, IO_BASE + 32'h8, 32'h1234, lat, nrd, nwr, rdata, flt);
    chk("iobad_fault",   {31'b0, flt}, 32'h1);
    chk("iobad_lat",     lat, 1);
    chk("iobad_outport", bus0.oOutPort, 32'hA5);
    @(negedge iClk);
    chk("fault_held", {31'b0, bus0.oFault}, 32'h1);

    do_xact(1'b0, 32'h10, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("post_fault_clr",  {31'b0, flt}, 32'h0);
    chk("post_fault_data", rdata, 32'hDEAD_BEEF);

    // iReq held high: reads of 0x10 every 4 cycles, ACK cycle never starts an access
    acks = 0; first_ack = 0; last_ack = 0; rd_cyc = 0;
    @(negedge iClk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    for (int c = 1; c <= 16; c++) begin
      @(negedge iClk);
      if (bus0.oMemRead) rd_cyc++;
      if (bus0.oAck) begin
        acks++;
        if (first_ack == 0) first_ack = c;
        last_ack = c;
      end
    end
    req = 1'b0;
    chk("b2b_acks",  acks, 4);
    chk("b2b_first", first_ack, 3);
    chk("b2b_last",  last_ack, 15);
    chk("b2b_rdcyc", rd_cyc, 8);

    // reset asserted during the memory write cycle
    @(negedge iClk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5555_5555;
    @(posedge iClk);
    #1;
    req = 1'b0;
    chk("mw_strobe_on", {31'b0, bus0.oMemWrite}, 32'h1);
    nRst = 1'b0;
    #1;
    chk("mw_strobe_off", {31'b0, bus0.oMemWrite}, 32'h0);
    chk("mw_ack_off",    {31'b0, bus0.oAck},      32'h0);
    chk("mw_outport",    bus0.oOutPort,           32'h0);
    chk("mw_data",       bus0.oData,              32'h0);
    @(posedge iClk);
    @(negedge iClk);
    nRst = 1'b1;
    @(negedge iClk);
    chk("mw_idle_strobes", {30'b0, bus0.oMemRead, bus0.oMemWrite}, 32'h0);
    chk("mw_mem_kept", mem0[8], 32'h0BAD_C0DE);
    do_xact(1'b0, 32'h20, 32'h0, lat, nrd, nwr, rdata, flt);
    chk("mw_read_lat",  lat, 3);
    chk("mw_read_data", rdata, 32'h0BAD_C0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
